// File: rtl/prng_lehmer.sv
// Park-Miller (Lehmer) PRNG: rand_val = (MULT * operand) mod (2^31-1), using a shift-add multiply over MULT_W cycles.
// Define PRNG_CONT_EN so that cont=1 reseeds from the previous result.
module prng_lehmer #(
  parameter int MULT   = 16807,
  parameter int MULT_W = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed,
  input  logic        start,
  input  logic        cont,
  output logic        done,
  output logic [31:0] rand_val
);

  localparam logic [31:0] MOD = 32'h7FFF_FFFF;
  localparam int AW = 31 + MULT_W;
  localparam int CW = $clog2(MULT_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_RED, S_DONE} state_t;

  state_t state, nxt;

  logic [31:0]       op;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     mcand;
  logic [MULT_W-1:0] mreg;
  logic [CW-1:0]     cnt;
  logic              red_ph;
  logic [31:0]       x;

  logic [31:0] pre_sum, pre_red, fin;
  logic [30:0] s_pre;
  logic [31:0] src;

`ifdef PRNG_CONT_EN
  assign src = cont ? rand_val : seed;
`else
  logic unused_cont;
  assign unused_cont = cont;
  assign src = seed;
`endif

  // Fold bit 31 back in (2^31 == 1 mod m); a zero operand would lock the sequence, so use 1.
  assign pre_sum = {1'b0, op[30:0]} + {31'b0, op[31]};
  assign pre_red = (pre_sum >= MOD) ? pre_sum - MOD : pre_sum;
  assign s_pre   = (pre_red == 32'd0) ? 31'd1 : pre_red[30:0];
  assign fin     = (x >= MOD) ? x - MOD : x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = S_LOAD;
      S_LOAD: nxt = S_MUL;
      S_MUL:  if (cnt == CW'(MULT_W - 1)) nxt = S_RED;
      S_RED:  if (red_ph) nxt = S_DONE;
      S_DONE: if (!start) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= '0;
      acc      <= '0;
      mcand    <= '0;
      mreg     <= '0;
      cnt      <= '0;
      red_ph   <= 1'b0;
      x        <= '0;
      done     <= 1'b0;
      rand_val <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) op <= src;
        end
        S_LOAD: begin
          acc    <= '0;
          mcand  <= {{(AW-31){1'b0}}, s_pre};
          mreg   <= MULT[MULT_W-1:0];
          cnt    <= '0;
          red_ph <= 1'b0;
        end
        S_MUL: begin
          if (mreg[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mreg  <= mreg >> 1;
          cnt   <= cnt + 1'b1;
        end
        S_RED: begin
          // acc[AW-1:31] is weighted by 2^31 == 1 mod m, so x stays below 2m.
          if (!red_ph) begin
            x      <= {1'b0, acc[30:0]} + {{(32-MULT_W){1'b0}}, acc[AW-1:31]};
            red_ph <= 1'b1;
          end else begin
            rand_val <= fin;
            done     <= 1'b1;
          end
        end
        S_DONE: if (!start) done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_lehmer.sv
// Scoreboard bench for prng_lehmer: expected values come from a 64-bit modular reference model.
module tb_prng_lehmer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seed = '0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        done;
  logic [31:0] rand_val;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  localparam longint MODL = 64'h7FFF_FFFF;

  prng_lehmer dut (
    .clk(clk), .rst(rst), .seed(seed), .start(start), .cont(cont),
    .done(done), .rand_val(rand_val)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] op);
    longint s;
    s = longint'(op[30:0]) + longint'(op[31]);
    if (s >= MODL) s = s - MODL;
    if (s == 0) s = 1;
    return 32'((longint'(16807) * s) % MODL);
  endfunction

  // Launch one generation; returns observed latency in edges (-1 on timeout).
  task automatic launch(input logic [31:0] sd, input logic ct, output int lat);
    logic [31:0] e;
    int n;
    @(negedge clk);
    seed = sd; cont = ct; start = 1'b1;
`ifdef PRNG_CONT_EN
    e = ct ? model(last_exp) : model(sd);
`else
    e = model(sd);
`endif
    exp_q.push_back(e);
    last_exp = e;
    n = 0; lat = -1;
    while (n < 60) begin
      @(posedge clk); n++;
      #1;
      if (done) begin lat = n - 1; break; end
    end
    if (lat < 0) begin
      compared++; mismatched++;
      $display("FAIL done_timeout: done=%0b after %0d edges, required 1", done, n);
    end
  endtask

  task automatic finish_handshake(input string name);
    logic [31:0] e;
    int n;
    @(negedge clk);
    start = 1'b0; seed = 32'hDEAD_BEEF; cont = 1'b0;
    n = 0;
    while (done && n < 10) begin @(posedge clk); #1; n++; end
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_done_drop: done=%0b, required 0", name, done);
    end
    e = exp_q.pop_front();
    compared++;
    if (rand_val !== e) begin
      mismatched++;
      $display("FAIL %s_rand: got %08h, required %08h", name, rand_val, e);
    end
  endtask

  task automatic test_reset;
    #100;
    rst = 1'b0;
    #1;
    compared++;
    if (done !== 1'b0 || rand_val !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_state: done=%0b rand=%08h, required 0 / 00000000", done, rand_val);
    end
  endtask

  task automatic test_latency;
    int lat;
    launch(32'h7B81_8935, 1'b0, lat);
    compared++;
    if (lat != 18) begin
      mismatched++;
      $display("FAIL latency: got %0d edges, required 18", lat);
    end
    finish_handshake("latency");
  endtask

  task automatic test_vectors;
    logic [31:0] seeds[4] = '{32'h142E_4ECE, 32'h6849_3A1B, 32'h73F1_2C81, 32'h0000_0005};
    int lat;
    for (int i = 0; i < 4; i++) begin
      launch(seeds[i], 1'b0, lat);
      finish_handshake("vector");
    end
    for (int i = 0; i < 3; i++) begin
      launch($urandom, 1'b0, lat);
      finish_handshake("random");
    end
  endtask

  task automatic test_degenerate;
    logic [31:0] seeds[3] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    int lat;
    for (int i = 0; i < 3; i++) begin
      launch(seeds[i], 1'b0, lat);
      compared++;
      if (rand_val !== 32'h0000_41A7) begin
        mismatched++;
        $display("FAIL degenerate_%08h: got %08h, required 000041a7", seeds[i], rand_val);
      end
      finish_handshake("degenerate");
    end
  endtask

  task automatic test_hold;
    logic [31:0] held;
    int lat, bad;
    launch(32'h1234_5678, 1'b0, lat);
    held = rand_val;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || rand_val !== held) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (done !== 1'b0 || rand_val !== held) begin
      mismatched++;
      $display("FAIL hold_release: done=%0b rand=%08h, required 0 / %08h", done, rand_val, held);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_early_drop;
    logic [31:0] e;
    int n, width;
    @(negedge clk);
    seed = 32'h0BAD_F00D; cont = 1'b0; start = 1'b1;
    e = model(32'h0BAD_F00D);
    last_exp = e;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    width = 0;
    while (done && width < 10) begin @(posedge clk); #1; width++; end
    compared++;
    if (width != 1) begin
      mismatched++;
      $display("FAIL early_pulse: done width %0d cycles, required 1", width);
    end
    compared++;
    if (rand_val !== e) begin
      mismatched++;
      $display("FAIL early_rand: got %08h, required %08h", rand_val, e);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    seed = 32'h5555_AAAA; start = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    compared++;
    if (done !== 1'b0 || rand_val !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_mid: done=%0b rand=%08h, required 0 / 00000000", done, rand_val);
    end
    start = 1'b0;
    last_exp = '0;
    @(negedge clk); rst = 1'b0;
    launch(32'h7B81_8935, 1'b0, lat);
    finish_handshake("after_reset");
  endtask

  task automatic test_cont;
    int lat;
    launch(32'h7B81_8935, 1'b0, lat);
    finish_handshake("cont_base");
    launch(32'h0000_0000, 1'b1, lat);
    finish_handshake("cont_chain");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_degenerate();
    test_hold();
    test_early_drop();
    test_reset_mid();
    test_cont();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prng_lehmer.md
Name: prng_lehmer

Overview:
- Multi-cycle Park–Miller (Lehmer) pseudo-random number generator.
- Computes rand = (A × operand) mod (2^31−1), with A = 16807 by default.
- A start/done four-phase handshake launches each generation and returns the 32-bit result.
- Sits as a peripheral next to a controller that supplies seeds and consumes the random values.

Parameters:
- MULT, 16807: multiplier constant A. Must be less than 2^MULT_W.
- MULT_W, 15: width of MULT in bits. Sets the number of shift-add cycles.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- seed  in  32  seed operand, sampled when a generation launches.
- start  in  1  request; held high by the requester until done is seen.
- cont  in  1  continue-from-last-result select (see Optional Feature).
- done  out  1  result valid; high from completion until start drops.
- rand  out  32  result; bit 31 always 0; held until the next result is written.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE, done=0, rand=0, all internal registers cleared.
- Modulus m = 2^31−1 (0x7FFFFFFF), fixed.
- FSM states are IDLE, LOAD, MUL, RED, DONE.
- IDLE:
  - done=0.
  - When start=1 at a rising edge, latch the operand source and go to LOAD.
- LOAD (1 cycle):
  - Pre-reduce the operand: s = op[30:0] + op[31]; if s ≥ m then s −= m.
  - If s = 0 (seed 0, 0x7FFFFFFF or 0xFFFFFFFF), substitute s = 1. This prevents the generator locking at zero.
- MUL (MULT_W cycles):
  - LSB-first shift-add of s by MULT into a 46-bit accumulator.
  - Exactly one bit of MULT is consumed per cycle.
- RED (2 cycles):
  - Cycle 1: x = acc[30:0] + acc[45:31].
  - Cycle 2: if x ≥ m then x −= m.
  - The result is then in 1..m−1.
- Completion: on the edge leaving RED, rand ← result, done ← 1, and the FSM goes to DONE.
- Latency: done rises on the (MULT_W+3)th rising edge after the edge that sampled start (18 with defaults).
- DONE:
  - done=1 and rand is stable.
  - Stay while start=1.
  - On the first edge with start=0: done ← 0 and go to IDLE. rand keeps its value.
- Start dropped early (before DONE): the computation still completes. DONE is entered and done pulses high for one cycle, then the FSM returns to IDLE.
- start high again in IDLE: a new generation launches on that edge. start must first fall for the DONE→IDLE exit to happen.
- seed and cont are sampled only in IDLE on the launching edge. Later changes are ignored until the next launch.
- Reset mid-operation aborts the generation; rand returns to 0.

Optional Feature:
- Macro: PRNG_CONT_EN.
- Defined: if cont=1 on the launching edge, the operand is the current rand register instead of seed. This chains the sequence without a bus round-trip. If cont=0, the operand is seed.
- Not defined: cont is ignored and the operand is always seed. The port still exists and is left unconnected internally.

Test Plan:
- Reset held 100 ns, then released → done=0, rand=0x00000000. start=1 → done rises exactly 18 clocks later.
- Sequential handshake cases; each holds start until done=1, then drops start and waits for done=0 before checking rand:
  - seed=0x7B818935 → rand=0x755735EB.
  - seed=0x142E4ECE → 0x6C37C0BB.
  - seed=0x68493A1B → 0x1F85F81A.
  - seed=0x73F12C81 → 0x5EA1049E.
- Degenerate seeds 0x00000000, 0x7FFFFFFF and 0xFFFFFFFF → rand=0x000041A7 in each case.
- Hold start=1 for 40 clocks after done rises → done stays 1 and rand stays constant. Drop start → done=0 on the next edge, and rand is unchanged.
- Assert rst during MUL → done=0 and rand=0 immediately, without waiting for a clock edge. A subsequent start with seed=0x7B818935 → 0x755735EB.
- With PRNG_CONT_EN: run seed=0x7B818935, then launch with cont=1 and seed=0 → the result equals the result of a plain run with seed=0x755735EB. The same stimulus without the macro → 0x000041A7.
